// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_pkg
//  Description : Shared state encodings for the countdown timer.
//  Revision    : 1.0
// ============================================================================
package countdown_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cd_state_e;

endpackage : countdown_pkg
`default_nettype wire

// File: rtl/countdown.sv
`default_nettype none
// ============================================================================
//  Module      : countdown
//  Description : Loadable down-counter with auto-reload and expiry pulse.
//  Revision    : 1.0
// ============================================================================
module countdown
    import countdown_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             reload_i,
    input  logic             stop_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             expire_o
);

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    cd_state_e        state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expire_q, expire_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            count_q  <= C_ZERO;
            reload_q <= C_ZERO;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    // Priority: load, then stop, then counting; expiry is only ever a one-cycle pulse.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;

        if (load_i) begin
            count_d  = load_val_i;
            reload_d = load_val_i;
            state_d  = (load_val_i != C_ZERO) ? ST_RUN : ST_IDLE;
        end else if (stop_i) begin
            count_d = C_ZERO;
            state_d = ST_IDLE;
        end else if (state_q == ST_RUN && en_i) begin
            if (count_q > C_ONE) begin
                count_d = count_q - C_ONE;
            end else if (count_q == C_ONE) begin
                expire_d = 1'b1;
                if (reload_i) begin
                    count_d = reload_q;
                end else begin
                    count_d = C_ZERO;
                    state_d = ST_IDLE;
                end
            end else begin
                // Zero count in RUN is unreachable; fall back to IDLE rather than wrap.
                state_d = ST_IDLE;
            end
        end
    end

    assign count_o  = count_q;
    assign busy_o   = (state_q == ST_RUN);
    assign expire_o = expire_q;

endmodule : countdown
`default_nettype wire
